// File: rtl/line_matrix_pkg.sv
// Shared constants for the accessory GPO line matrix and its sequencer.
package line_matrix_pkg;

    localparam int unsigned LM_NUM_OUT = 10;
    localparam int unsigned LM_SEL_W   = 4;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RST   = 3'd1;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd2;
    localparam logic [ST_W-1:0] ST_HIGH  = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_matrix_sequencer_if.sv
// Command/status bundle between the register bank and the line matrix sequencer.
interface line_matrix_sequencer_if
    import line_matrix_pkg::*;
#(
    parameter int unsigned SEL_W = LM_SEL_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_in_sel;
    logic [SEL_W-1:0] cmd_out_sel;
    logic             clr_req;
    logic             replay_req;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_in_sel, cmd_out_sel, clr_req, replay_req,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_in_sel, cmd_out_sel, clr_req, replay_req,
        output cmd_ready, busy, done, err
    );

endinterface

// File: rtl/line_matrix_sequencer.sv
// Generates timed mx_clk/mx_rstn strobes and select buses for the GPO line matrix,
// keeping a shadow of the programmed routing that can be replayed after a matrix reset.
module line_matrix_sequencer
    import line_matrix_pkg::*;
#(
    parameter int unsigned NUM_OUT   = LM_NUM_OUT,
    parameter int unsigned SEL_W     = LM_SEL_W,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HIGH_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned RST_CYC   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    line_matrix_sequencer_if.slave bus,
    input  logic [SEL_W-1:0]       shadow_addr,
    output logic [SEL_W-1:0]       shadow_data,
    output logic                   mx_clk,
    output logic                   mx_rstn,
    output logic [SEL_W-1:0]       mx_input_select,
    output logic [SEL_W-1:0]       mx_output_select
);

    localparam int unsigned MAX_CYC = max2(max2(SETUP_CYC, HIGH_CYC), max2(HOLD_CYC, RST_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [ST_W-1:0]  state, next_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] idx, idx_nxt;
    logic [SEL_W-1:0] in_nxt, out_nxt;
    logic [SEL_W-1:0] rep_sel, rep_data;
    logic             replay, replay_nxt;
    logic             err_nxt, done_nxt;
    logic             take, shadow_we, shadow_clr, cmd_oor;
    logic [SEL_W-1:0] shadow [NUM_OUT];

    assign cmd_oor = 32'(bus.cmd_out_sel) >= NUM_OUT;

    // Replay always presents the entry that the next SETUP will drive.
    assign rep_sel = (state == ST_HOLD) ? idx + SEL_W'(1) : '0;

    always_comb begin
        shadow_data = '0;
        rep_data    = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (shadow_addr == SEL_W'(i)) shadow_data = shadow[i];
            if (rep_sel == SEL_W'(i))     rep_data    = shadow[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state, counter reload and select updates; counter reloads on every state entry.
    always_comb begin
        next_state = state;
        cnt_nxt    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        idx_nxt    = idx;
        replay_nxt = replay;
        in_nxt     = mx_input_select;
        out_nxt    = mx_output_select;
        err_nxt    = bus.err;
        done_nxt   = 1'b0;
        take       = 1'b0;
        shadow_we  = 1'b0;
        shadow_clr = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    take       = 1'b1;
                    next_state = ST_RST;
                    cnt_nxt    = CNT_W'(RST_CYC - 1);
                end else if (bus.replay_req) begin
                    take       = 1'b1;
                    next_state = ST_SETUP;
                    cnt_nxt    = CNT_W'(SETUP_CYC - 1);
                    replay_nxt = 1'b1;
                    idx_nxt    = '0;
                    out_nxt    = '0;
                    in_nxt     = rep_data;
                end else if (bus.cmd_valid && bus.cmd_ready) begin
                    take = 1'b1;
                    if (cmd_oor) begin
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        next_state = ST_SETUP;
                        cnt_nxt    = CNT_W'(SETUP_CYC - 1);
                        replay_nxt = 1'b0;
                        in_nxt     = bus.cmd_in_sel;
                        out_nxt    = bus.cmd_out_sel;
                    end
                end
            end
            ST_RST: begin
                if (cnt == '0) begin
                    next_state = ST_IDLE;
                    shadow_clr = 1'b1;
                    err_nxt    = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    next_state = ST_HIGH;
                    cnt_nxt    = CNT_W'(HIGH_CYC - 1);
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    next_state = ST_HOLD;
                    cnt_nxt    = CNT_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (!replay) begin
                        shadow_we  = 1'b1;
                        done_nxt   = 1'b1;
                        next_state = ST_IDLE;
                    end else if (idx == SEL_W'(NUM_OUT - 1)) begin
                        replay_nxt = 1'b0;
                        done_nxt   = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        idx_nxt    = rep_sel;
                        out_nxt    = rep_sel;
                        in_nxt     = rep_data;
                        next_state = ST_SETUP;
                        cnt_nxt    = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from next_state so they align with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt              <= '0;
            idx              <= '0;
            replay           <= 1'b0;
            mx_clk           <= 1'b0;
            mx_rstn          <= 1'b0;
            mx_input_select  <= '0;
            mx_output_select <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.cmd_ready    <= 1'b0;
            for (int i = 0; i < int'(NUM_OUT); i++) shadow[i] <= '0;
        end else begin
            cnt              <= cnt_nxt;
            idx              <= idx_nxt;
            replay           <= replay_nxt;
            mx_clk           <= (next_state == ST_HIGH);
            mx_rstn          <= (next_state != ST_RST);
            mx_input_select  <= in_nxt;
            mx_output_select <= out_nxt;
            bus.busy         <= (next_state != ST_IDLE);
            bus.done         <= done_nxt;
            bus.err          <= err_nxt;
            bus.cmd_ready    <= (state == ST_IDLE) && (next_state == ST_IDLE) && !take;
            if (shadow_clr) begin
                for (int i = 0; i < int'(NUM_OUT); i++) shadow[i] <= '0;
            end else if (shadow_we) begin
                for (int i = 0; i < int'(NUM_OUT); i++) begin
                    if (mx_output_select == SEL_W'(i)) shadow[i] <= mx_input_select;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_matrix_sequencer.sv
// Directed bench for line_matrix_sequencer: command timing, errors, clear, replay, priority, async reset.
module tb_line_matrix_sequencer;
    import line_matrix_pkg::*;

    localparam int unsigned NUM_OUT = 10;
    localparam int unsigned SEL_W   = 4;

    logic             clk;
    logic             rstn;
    logic [SEL_W-1:0] shadow_addr;
    logic [SEL_W-1:0] shadow_data;
    logic             mx_clk;
    logic             mx_rstn;
    logic [SEL_W-1:0] mx_input_select;
    logic [SEL_W-1:0] mx_output_select;

    int total;
    int bad;
    logic [SEL_W-1:0] model [NUM_OUT];

    line_matrix_sequencer_if #(.SEL_W(SEL_W)) bus ();

    line_matrix_sequencer #(
        .NUM_OUT  (NUM_OUT),
        .SEL_W    (SEL_W),
        .SETUP_CYC(2),
        .HIGH_CYC (2),
        .HOLD_CYC (1),
        .RST_CYC  (4)
    ) u_dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .shadow_addr     (shadow_addr),
        .shadow_data     (shadow_data),
        .mx_clk          (mx_clk),
        .mx_rstn         (mx_rstn),
        .mx_input_select (mx_input_select),
        .mx_output_select(mx_output_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_shadow(input logic [SEL_W-1:0] a, output logic [SEL_W-1:0] d);
        shadow_addr = a;
        #1;
        d = shadow_data;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(bus.done), 32'd1);
    endtask

    task automatic do_cmd(input logic [SEL_W-1:0] i, input logic [SEL_W-1:0] o);
        wait_ready();
        bus.cmd_in_sel  = i;
        bus.cmd_out_sel = o;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done();
        if (32'(o) < NUM_OUT) model[o] = i;
    endtask

    initial begin
        logic [SEL_W-1:0] d;
        logic             saw_clk;
        logic             prev_clk;
        int               rises;
        int               dones;
        int               done_cyc;

        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        shadow_addr     = '0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_in_sel  = '0;
        bus.cmd_out_sel = '0;
        bus.clr_req     = 1'b0;
        bus.replay_req  = 1'b0;
        for (int k = 0; k < int'(NUM_OUT); k++) model[k] = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_mx_clk",    32'(mx_clk),           32'd0);
        chk("rst_mx_rstn",   32'(mx_rstn),          32'd0);
        chk("rst_in_sel",    32'(mx_input_select),  32'd0);
        chk("rst_out_sel",   32'(mx_output_select), 32'd0);
        chk("rst_busy",      32'(bus.busy),         32'd0);
        chk("rst_done",      32'(bus.done),         32'd0);
        chk("rst_err",       32'(bus.err),          32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready),    32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_mx_rstn",   32'(mx_rstn),       32'd1);
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single command in=3 out=5: strobe in cycles 3-4, done in cycle 6
        bus.cmd_in_sel  = 4'd3;
        bus.cmd_out_sel = 4'd5;
        bus.cmd_valid   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.cmd_valid = 1'b0;
            chk($sformatf("cmd_mx_clk_c%0d", c), 32'(mx_clk),    32'(c == 3 || c == 4));
            chk($sformatf("cmd_done_c%0d", c),   32'(bus.done),  32'(c == 6));
            chk($sformatf("cmd_busy_c%0d", c),   32'(bus.busy),  32'(c >= 1 && c <= 5));
            chk($sformatf("cmd_ready_c%0d", c),  32'(bus.cmd_ready), 32'(c == 7));
            if (c >= 1 && c <= 5) begin
                chk($sformatf("cmd_in_sel_c%0d", c),  32'(mx_input_select),  32'd3);
                chk($sformatf("cmd_out_sel_c%0d", c), 32'(mx_output_select), 32'd5);
            end
        end
        model[5] = 4'd3;
        read_shadow(4'd5, d);
        chk("cmd_shadow5", 32'(d), 32'd3);

        // Out-of-range command: err and done together, no strobe, shadow untouched
        wait_ready();
        bus.cmd_in_sel  = 4'd7;
        bus.cmd_out_sel = 4'd12;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("oor_err",   32'(bus.err),       32'd1);
        chk("oor_done",  32'(bus.done),      32'd1);
        chk("oor_busy",  32'(bus.busy),      32'd0);
        chk("oor_ready", 32'(bus.cmd_ready), 32'd0);
        saw_clk = mx_clk;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mx_clk) saw_clk = 1'b1;
        end
        chk("oor_no_strobe", 32'(saw_clk), 32'd0);
        chk("oor_err_sticky", 32'(bus.err), 32'd1);
        read_shadow(4'd5, d);
        chk("oor_shadow5", 32'(d), 32'd3);
        read_shadow(4'd12, d);
        chk("oor_readback_12", 32'(d), 32'd0);

        // Program every output with in = out mod 8
        for (int o = 0; o < int'(NUM_OUT); o++) do_cmd(4'(o % 8), 4'(o));
        for (int o = 0; o < int'(NUM_OUT); o++) begin
            read_shadow(4'(o), d);
            chk($sformatf("prog_shadow%0d", o), 32'(d), 32'(o % 8));
        end
        chk("prog_err_sticky", 32'(bus.err), 32'd1);

        // Clear: mx_rstn low for cycles 1-4, done in cycle 5, shadow and err cleared
        wait_ready();
        bus.clr_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.clr_req = 1'b0;
            chk($sformatf("clr_mx_rstn_c%0d", c), 32'(mx_rstn),  32'(!(c <= 4)));
            chk($sformatf("clr_done_c%0d", c),    32'(bus.done), 32'(c == 5));
        end
        chk("clr_err", 32'(bus.err), 32'd0);
        for (int k = 0; k < int'(NUM_OUT); k++) model[k] = '0;
        for (int o = 0; o < int'(NUM_OUT); o++) begin
            read_shadow(4'(o), d);
            chk($sformatf("clr_shadow%0d", o), 32'(d), 32'd0);
        end

        // Replay: ten strobes stepping 0..9 with shadow contents, one done at cycle 51
        do_cmd(4'd6,  4'd1);
        do_cmd(4'd9,  4'd4);
        do_cmd(4'd2,  4'd7);
        do_cmd(4'd15, 4'd9);
        wait_ready();
        bus.replay_req = 1'b1;
        prev_clk = 1'b0;
        rises    = 0;
        dones    = 0;
        done_cyc = 0;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            if (c == 1) bus.replay_req = 1'b0;
            if (mx_clk && !prev_clk) begin
                chk($sformatf("rep_out_sel_%0d", rises), 32'(mx_output_select), 32'(rises));
                chk($sformatf("rep_in_sel_%0d", rises),  32'(mx_input_select),  32'(model[rises]));
                rises++;
            end
            if (bus.done) begin
                dones++;
                done_cyc = c;
            end
            prev_clk = mx_clk;
        end
        chk("rep_rises",    32'(rises),    32'd10);
        chk("rep_dones",    32'(dones),    32'd1);
        chk("rep_done_cyc", 32'(done_cyc), 32'd51);

        // clr_req and cmd_valid together: clear first, then the held command runs
        wait_ready();
        bus.clr_req     = 1'b1;
        bus.cmd_in_sel  = 4'd5;
        bus.cmd_out_sel = 4'd2;
        bus.cmd_valid   = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) bus.clr_req = 1'b0;
            if (c == 7) bus.cmd_valid = 1'b0;
            chk($sformatf("pri_mx_rstn_c%0d", c), 32'(mx_rstn),       32'(!(c <= 4)));
            chk($sformatf("pri_done_c%0d", c),    32'(bus.done),      32'(c == 5 || c == 12));
            chk($sformatf("pri_mx_clk_c%0d", c),  32'(mx_clk),        32'(c == 9 || c == 10));
            chk($sformatf("pri_ready_c%0d", c),   32'(bus.cmd_ready), 32'(c == 6 || c == 13));
        end
        read_shadow(4'd2, d);
        chk("pri_shadow2", 32'(d), 32'd5);
        read_shadow(4'd9, d);
        chk("pri_shadow9", 32'(d), 32'd0);

        // Async reset during HIGH: outputs drop at once, shadow entry never written
        wait_ready();
        bus.cmd_in_sel  = 4'd4;
        bus.cmd_out_sel = 4'd3;
        bus.cmd_valid   = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) bus.cmd_valid = 1'b0;
        end
        chk("ar_mx_clk_before", 32'(mx_clk), 32'd1);
        rstn = 1'b0;
        #1;
        chk("ar_mx_clk",  32'(mx_clk),           32'd0);
        chk("ar_mx_rstn", 32'(mx_rstn),          32'd0);
        chk("ar_busy",    32'(bus.busy),         32'd0);
        chk("ar_out_sel", 32'(mx_output_select), 32'd0);
        chk("ar_ready",   32'(bus.cmd_ready),    32'd0);
        @(negedge clk);
        chk("ar_mx_clk_held", 32'(mx_clk), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ar_rel_ready", 32'(bus.cmd_ready), 32'd1);
        chk("ar_rel_busy",  32'(bus.busy),      32'd0);
        chk("ar_rel_rstn",  32'(mx_rstn),       32'd1);
        read_shadow(4'd3, d);
        chk("ar_shadow3", 32'(d), 32'd0);
        read_shadow(4'd2, d);
        chk("ar_shadow2", 32'(d), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
